pwm_in_debounce: RTL and testbench

Per-bit glitch filter and edge detector for external inputs after the two-flop synchronizer (`prim_ff_2sync`) in the pwm_ramp IP. It sits directly downstream of that synchronizer and takes its `q_o` as `d_i`. Each bit's debounced level changes only after the new value has been stable for a programmable number of cycles. Single-cycle rise/fall pulses go to the PWM ramp control logic.

---
 rtl/pwm_ramp_pkg.sv | 15 +
 rtl/pwm_in_debounce_bit.sv | 70 +++++++
 rtl/pwm_in_debounce.sv | 46 ++++
 tb/tb_pwm_in_debounce.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ramp_pkg.sv
//------------------------------------------------------------------------------
// Module      : pwm_ramp_pkg
// Description : Shared constants for the pwm_ramp IP input conditioning path.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pwm_ramp_pkg;

  // Default width of the per-bit debounce stability counter
  localparam int DebounceCntW = 8;

endpackage : pwm_ramp_pkg

`default_nettype wire

// File: rtl/pwm_in_debounce_bit.sv
//------------------------------------------------------------------------------
// Module      : pwm_in_debounce_bit
// Description : One-bit glitch filter with registered level, stability counter
//               and single-cycle rise/fall pulses.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pwm_in_debounce_bit #(
  parameter int   CntWidth = 8,
  parameter logic ResetBit = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [CntWidth-1:0] thresh_i,
  input  logic                d_i,
  output logic                q_o,
  output logic                rise_o,
  output logic                fall_o
);

  logic                level_q, level_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;

  // Next-state: count disagreeing samples, accept the new level once the
  // count has reached the threshold (>= so a lowered threshold acts at once)
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
    end else if (d_i == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= thresh_i) begin
      level_d = d_i;
      cnt_d   = '0;
      rise_d  = d_i;
      fall_d  = ~d_i;
    end else begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  // State and output registers; reset wins over everything
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      level_q <= ResetBit;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign q_o    = level_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule : pwm_in_debounce_bit

`default_nettype wire

// File: rtl/pwm_in_debounce.sv
//------------------------------------------------------------------------------
// Module      : pwm_in_debounce
// Description : Per-bit glitch filter and edge detector placed after the
//               two-flop synchronizer; fans out enable and threshold to
//               Width independent bit filters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pwm_in_debounce
  import pwm_ramp_pkg::*;
#(
  parameter int               Width      = 4,
  parameter int               CntWidth   = DebounceCntW,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [CntWidth-1:0] thresh_i,
  input  logic [Width-1:0]    d_i,
  output logic [Width-1:0]    q_o,
  output logic [Width-1:0]    rise_o,
  output logic [Width-1:0]    fall_o
);

  // One independent filter per input bit
  for (genvar i = 0; i < Width; i++) begin : g_bit
    pwm_in_debounce_bit #(
      .CntWidth (CntWidth),
      .ResetBit (ResetValue[i])
    ) u_bit (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en_i     (en_i),
      .thresh_i (thresh_i),
      .d_i      (d_i[i]),
      .q_o      (q_o[i]),
      .rise_o   (rise_o[i]),
      .fall_o   (fall_o[i])
    );
  end : g_bit

endmodule : pwm_in_debounce

`default_nettype wire

// File: tb/tb_pwm_in_debounce.sv
//------------------------------------------------------------------------------
// Module      : tb_pwm_in_debounce
// Description : Self-checking bench for pwm_in_debounce: directed scenarios
//               followed by random stimulus against a streak-based model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pwm_in_debounce;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [CW-1:0] thresh;
  logic [W-1:0]  d;
  logic [W-1:0]  q, rise, fall;

  int errors = 0;
  int checks = 0;

  // Reference state: modelled level, pulses, and length of the current run
  // of enabled samples that disagree with the level
  logic [W-1:0] m_q, m_rise, m_fall;
  int           streak [W];

  pwm_in_debounce #(
    .Width      (W),
    .CntWidth   (CW),
    .ResetValue ('0)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .en_i     (en),
    .thresh_i (thresh),
    .d_i      (d),
    .q_o      (q),
    .rise_o   (rise),
    .fall_o   (fall)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A new level is accepted once it has been seen on more than thresh
  // consecutive enabled edges; any agreeing sample or disable ends the run.
  task automatic model_edge();
    m_rise = '0;
    m_fall = '0;
    if (!rst_n) begin
      m_q = '0;
      for (int b = 0; b < W; b++) streak[b] = 0;
    end else begin
      for (int b = 0; b < W; b++) begin
        if (!en || d[b] == m_q[b]) begin
          streak[b] = 0;
        end else begin
          streak[b] = streak[b] + 1;
          if (streak[b] > int'(thresh)) begin
            m_q[b]    = d[b];
            m_rise[b] = d[b];
            m_fall[b] = ~d[b];
            streak[b] = 0;
          end
        end
      end
    end
  endtask

  // One clock: model follows the DUT edge, outputs sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("q_model", q, m_q);
    chk("rise_model", rise, m_rise);
    chk("fall_model", fall, m_fall);
  endtask

  initial begin
    m_q = '0; m_rise = '0; m_fall = '0;
    for (int b = 0; b < W; b++) streak[b] = 0;
    rst_n = 1'b0; en = 1'b1; thresh = CW'(3); d = 4'hF;

    // Reset held with all inputs high
    repeat (3) step();
    chk("reset_q", q, 4'h0);
    chk("reset_pulse", rise | fall, 4'h0);
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_reset_hold", q, 4'h0);
    chk("post_reset_nopulse", rise, 4'h0);
    step();
    chk("post_reset_accept", rise, 4'hF);
    d = 4'h0;
    repeat (4) step();
    chk("return_low", q, 4'h0);

    // Clean rising and falling edge on bit 0 with threshold 3
    d = 4'h1;
    repeat (3) step();
    chk("clean_wait", q, 4'h0);
    step();
    chk("clean_rise_q", q, 4'h1);
    chk("clean_rise_pulse", rise, 4'h1);
    step();
    chk("clean_rise_once", rise, 4'h0);
    d = 4'h0;
    repeat (3) step();
    step();
    chk("clean_fall_pulse", fall, 4'h1);

    // Glitch rejection on bit 1, then a 4-cycle pulse is accepted
    d = 4'h2;
    repeat (3) step();
    d = 4'h0;
    step();
    chk("glitch_reject", q, 4'h0);
    d = 4'h2;
    repeat (4) step();
    chk("glitch_accept", rise, 4'h2);
    d = 4'h0;
    repeat (4) step();

    // Transparent mode and simultaneous bits
    thresh = CW'(0);
    d = 4'hA;
    step();
    chk("transp_q", q, 4'hA);
    chk("transp_rise", rise, 4'hA);
    d = 4'h5;
    step();
    chk("simul_rise", rise, 4'h5);
    chk("simul_fall", fall, 4'hA);
    d = 4'h0;
    step();

    // Enable dropped mid-count discards the pending change
    thresh = CW'(10);
    d = 4'h4;
    repeat (5) step();
    en = 1'b0;
    repeat (2) step();
    en = 1'b1;
    repeat (10) step();
    chk("en_restart_wait", q, 4'h0);
    step();
    chk("en_restart_accept", rise, 4'h4);

    // Lowering the threshold mid-count flips on the next edge
    d = 4'h0;
    repeat (5) step();
    thresh = CW'(2);
    step();
    chk("thresh_lower", fall, 4'h4);

    // Reset mid-count on bit 3
    thresh = CW'(9);
    d = 4'h8;
    repeat (7) step();
    rst_n = 1'b0;
    step();
    chk("midrst_q", q, 4'h0);
    chk("midrst_pulse", rise | fall, 4'h0);
    rst_n = 1'b1;
    repeat (9) step();
    chk("midrst_restart", q, 4'h0);
    step();
    chk("midrst_accept", rise, 4'h8);

    // Random stimulus: bursty inputs, occasional disable/threshold/reset
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 7) == 0) d[b] = ~d[b];
      if ($urandom_range(0, 99) == 0) en = ~en;
      if (!en && $urandom_range(0, 3) == 0) thresh = CW'($urandom_range(0, 12));
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_pwm_in_debounce

`default_nettype wire
